// File: rtl/z80fi_retire_monitor_if.sv
// Monitor-side bus of the Z80FI retirement monitor: per-cycle access strobes from the
// sequencer (mon_*) and the registered retirement packet (z80fi_*).
interface z80fi_retire_monitor_if #(
  parameter int RNUM_W = 3
);
  logic              mon_start;
  logic [15:0]       mon_pc;
  logic              mon_byte_v;
  logic [7:0]        mon_byte;
  logic              mon_rd_v;
  logic [RNUM_W-1:0] mon_rd_num;
  logic [15:0]       mon_rd_data;
  logic              mon_wr_v;
  logic [RNUM_W-1:0] mon_wr_num;
  logic [15:0]       mon_wr_data;
  logic              mon_mrd_v;
  logic              mon_mwr_v;
  logic [15:0]       mon_maddr;
  logic [7:0]        mon_mdata;
  logic              mon_i_rd;
  logic              mon_i_wr;
  logic              mon_r_rd;
  logic              mon_r_wr;
  logic              mon_f_rd;
  logic              mon_f_wr;
  logic [7:0]        mon_sdata;
  logic              mon_done;
  logic [15:0]       mon_pc_next;

  logic              z80fi_valid;
  logic [31:0]       z80fi_insn;
  logic [2:0]        z80fi_insn_len;
  logic [15:0]       z80fi_pc_rdata;
  logic [15:0]       z80fi_pc_wdata;
  logic              z80fi_reg1_v;
  logic [RNUM_W-1:0] z80fi_reg1_num;
  logic [15:0]       z80fi_reg1_data;
  logic              z80fi_reg2_v;
  logic [RNUM_W-1:0] z80fi_reg2_num;
  logic [15:0]       z80fi_reg2_data;
  logic              z80fi_reg_wv;
  logic [RNUM_W-1:0] z80fi_reg_wnum;
  logic [15:0]       z80fi_reg_wdata;
  logic              z80fi_mem_rd_v;
  logic [15:0]       z80fi_mem_rd_addr;
  logic [7:0]        z80fi_mem_rd_data;
  logic              z80fi_mem_rd2_v;
  logic [15:0]       z80fi_mem_rd2_addr;
  logic [7:0]        z80fi_mem_rd2_data;
  logic              z80fi_mem_wr_v;
  logic [15:0]       z80fi_mem_wr_addr;
  logic [7:0]        z80fi_mem_wr_data;
  logic              z80fi_mem_wr2_v;
  logic [15:0]       z80fi_mem_wr2_addr;
  logic [7:0]        z80fi_mem_wr2_data;
  logic              z80fi_i_rd;
  logic [7:0]        z80fi_i_rdata;
  logic              z80fi_i_wr;
  logic [7:0]        z80fi_i_wdata;
  logic              z80fi_r_rd;
  logic [7:0]        z80fi_r_rdata;
  logic              z80fi_r_wr;
  logic [7:0]        z80fi_r_wdata;
  logic              z80fi_f_rd;
  logic [7:0]        z80fi_f_rdata;
  logic              z80fi_f_wr;
  logic [7:0]        z80fi_f_wdata;
  logic              z80fi_proto_err;

  modport master (
    output mon_start, mon_pc, mon_byte_v, mon_byte, mon_rd_v, mon_rd_num, mon_rd_data,
           mon_wr_v, mon_wr_num, mon_wr_data, mon_mrd_v, mon_mwr_v, mon_maddr, mon_mdata,
           mon_i_rd, mon_i_wr, mon_r_rd, mon_r_wr, mon_f_rd, mon_f_wr, mon_sdata,
           mon_done, mon_pc_next,
    input  z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata, z80fi_pc_wdata,
           z80fi_reg1_v, z80fi_reg1_num, z80fi_reg1_data,
           z80fi_reg2_v, z80fi_reg2_num, z80fi_reg2_data,
           z80fi_reg_wv, z80fi_reg_wnum, z80fi_reg_wdata,
           z80fi_mem_rd_v, z80fi_mem_rd_addr, z80fi_mem_rd_data,
           z80fi_mem_rd2_v, z80fi_mem_rd2_addr, z80fi_mem_rd2_data,
           z80fi_mem_wr_v, z80fi_mem_wr_addr, z80fi_mem_wr_data,
           z80fi_mem_wr2_v, z80fi_mem_wr2_addr, z80fi_mem_wr2_data,
           z80fi_i_rd, z80fi_i_rdata, z80fi_i_wr, z80fi_i_wdata,
           z80fi_r_rd, z80fi_r_rdata, z80fi_r_wr, z80fi_r_wdata,
           z80fi_f_rd, z80fi_f_rdata, z80fi_f_wr, z80fi_f_wdata,
           z80fi_proto_err
  );

  modport slave (
    input  mon_start, mon_pc, mon_byte_v, mon_byte, mon_rd_v, mon_rd_num, mon_rd_data,
           mon_wr_v, mon_wr_num, mon_wr_data, mon_mrd_v, mon_mwr_v, mon_maddr, mon_mdata,
           mon_i_rd, mon_i_wr, mon_r_rd, mon_r_wr, mon_f_rd, mon_f_wr, mon_sdata,
           mon_done, mon_pc_next,
    output z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata, z80fi_pc_wdata,
           z80fi_reg1_v, z80fi_reg1_num, z80fi_reg1_data,
           z80fi_reg2_v, z80fi_reg2_num, z80fi_reg2_data,
           z80fi_reg_wv, z80fi_reg_wnum, z80fi_reg_wdata,
           z80fi_mem_rd_v, z80fi_mem_rd_addr, z80fi_mem_rd_data,
           z80fi_mem_rd2_v, z80fi_mem_rd2_addr, z80fi_mem_rd2_data,
           z80fi_mem_wr_v, z80fi_mem_wr_addr, z80fi_mem_wr_data,
           z80fi_mem_wr2_v, z80fi_mem_wr2_addr, z80fi_mem_wr2_data,
           z80fi_i_rd, z80fi_i_rdata, z80fi_i_wr, z80fi_i_wdata,
           z80fi_r_rd, z80fi_r_rdata, z80fi_r_wr, z80fi_r_wdata,
           z80fi_f_rd, z80fi_f_rdata, z80fi_f_wr, z80fi_f_wdata,
           z80fi_proto_err
  );
endinterface

// File: rtl/z80fi_retire_monitor.sv
// Z80FI retirement monitor: gathers one instruction's accesses and emits one packet per retire.
// Optional sticky protocol-error flag is built when Z80FI_PROTO_CHECK_EN is defined.
//
// state   | meaning
// IDLE    | no instruction in flight; mon_done is ignored
// COLLECT | capturing strobes for the instruction started by mon_start
module z80fi_retire_monitor #(
  parameter int MAX_INSN_BYTES = 4,
  parameter int RNUM_W         = 3
) (
  input logic                   clk,
  input logic                   reset,
  z80fi_retire_monitor_if.slave bus
);

  typedef enum logic {IDLE, COLLECT} state_t;

  typedef struct packed {
    logic [15:0]       pc;
    logic [31:0]       insn;
    logic [2:0]        len;
    logic              reg1_v;
    logic [RNUM_W-1:0] reg1_num;
    logic [15:0]       reg1_data;
    logic              reg2_v;
    logic [RNUM_W-1:0] reg2_num;
    logic [15:0]       reg2_data;
    logic              regw_v;
    logic [RNUM_W-1:0] regw_num;
    logic [15:0]       regw_data;
    logic              mrd_v;
    logic [15:0]       mrd_addr;
    logic [7:0]        mrd_data;
    logic              mrd2_v;
    logic [15:0]       mrd2_addr;
    logic [7:0]        mrd2_data;
    logic              mwr_v;
    logic [15:0]       mwr_addr;
    logic [7:0]        mwr_data;
    logic              mwr2_v;
    logic [15:0]       mwr2_addr;
    logic [7:0]        mwr2_data;
    logic              i_rd;
    logic [7:0]        i_rdata;
    logic              i_wr;
    logic [7:0]        i_wdata;
    logic              r_rd;
    logic [7:0]        r_rdata;
    logic              r_wr;
    logic [7:0]        r_wdata;
    logic              f_rd;
    logic [7:0]        f_rdata;
    logic              f_wr;
    logic [7:0]        f_wdata;
  } cap_t;

  state_t      state;
  cap_t        cap_q;
  cap_t        out_q;
  logic [15:0] pc_next_q;
  logic        valid_q;
  cap_t        cap_clr;
  cap_t        cap_new;
  cap_t        cap_ret;

  // Fold this cycle's strobes into a capture image; first-come slots, last-wins writes.
  function automatic cap_t apply(input cap_t c);
    cap_t n;
    n = c;
    if (bus.mon_byte_v && (c.len < 3'(MAX_INSN_BYTES))) begin
      n.insn[{c.len[1:0], 3'b000} +: 8] = bus.mon_byte;
      n.len = c.len + 3'd1;
    end
    if (bus.mon_rd_v) begin
      if (!c.reg1_v) begin
        n.reg1_v = 1'b1; n.reg1_num = bus.mon_rd_num; n.reg1_data = bus.mon_rd_data;
      end else if (!c.reg2_v) begin
        n.reg2_v = 1'b1; n.reg2_num = bus.mon_rd_num; n.reg2_data = bus.mon_rd_data;
      end
    end
    if (bus.mon_wr_v) begin
      n.regw_v = 1'b1; n.regw_num = bus.mon_wr_num; n.regw_data = bus.mon_wr_data;
    end
    if (bus.mon_mrd_v) begin
      if (!c.mrd_v) begin
        n.mrd_v = 1'b1; n.mrd_addr = bus.mon_maddr; n.mrd_data = bus.mon_mdata;
      end else if (!c.mrd2_v) begin
        n.mrd2_v = 1'b1; n.mrd2_addr = bus.mon_maddr; n.mrd2_data = bus.mon_mdata;
      end
    end
    if (bus.mon_mwr_v) begin
      if (!c.mwr_v) begin
        n.mwr_v = 1'b1; n.mwr_addr = bus.mon_maddr; n.mwr_data = bus.mon_mdata;
      end else if (!c.mwr2_v) begin
        n.mwr2_v = 1'b1; n.mwr2_addr = bus.mon_maddr; n.mwr2_data = bus.mon_mdata;
      end
    end
    if (bus.mon_i_rd) begin n.i_rd = 1'b1; n.i_rdata = bus.mon_sdata; end
    if (bus.mon_i_wr) begin n.i_wr = 1'b1; n.i_wdata = bus.mon_sdata; end
    if (bus.mon_r_rd) begin n.r_rd = 1'b1; n.r_rdata = bus.mon_sdata; end
    if (bus.mon_r_wr) begin n.r_wr = 1'b1; n.r_wdata = bus.mon_sdata; end
    if (bus.mon_f_rd) begin n.f_rd = 1'b1; n.f_rdata = bus.mon_sdata; end
    if (bus.mon_f_wr) begin n.f_wr = 1'b1; n.f_wdata = bus.mon_sdata; end
    return n;
  endfunction

  // cap_new seeds the next instruction; cap_ret is the in-flight one plus this cycle.
  always_comb begin
    cap_clr    = '0;
    cap_clr.pc = bus.mon_pc;
    cap_new    = apply(cap_clr);
    cap_ret    = apply(cap_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cap_q     <= '0;
      out_q     <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mon_start) begin
            cap_q <= cap_new;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.mon_done) begin
            valid_q   <= 1'b1;
            out_q     <= cap_ret;
            pc_next_q <= bus.mon_pc_next;
          end
          if (bus.mon_start)     cap_q <= cap_new;
          else if (bus.mon_done) state <= IDLE;
          else                   cap_q <= cap_ret;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef Z80FI_PROTO_CHECK_EN
  logic proto_err_q;
  logic collecting;
  logic err_evt;

  function automatic logic drops(input cap_t c);
    return (bus.mon_byte_v && (c.len >= 3'(MAX_INSN_BYTES))) ||
           (bus.mon_rd_v && c.reg2_v) ||
           (bus.mon_mrd_v && c.mrd2_v) ||
           (bus.mon_mwr_v && c.mwr2_v);
  endfunction

  // The old capture only sees this cycle's strobes when it retires or keeps collecting.
  assign collecting = (state == COLLECT);
  assign err_evt = (bus.mon_done && !collecting) ||
                   (bus.mon_start && collecting && !bus.mon_done) ||
                   (bus.mon_start && drops(cap_clr)) ||
                   (collecting && (bus.mon_done || !bus.mon_start) && drops(cap_q));

  always_ff @(posedge clk) begin
    if (reset)        proto_err_q <= 1'b0;
    else if (err_evt) proto_err_q <= 1'b1;
  end

  assign bus.z80fi_proto_err = proto_err_q;
`else
  assign bus.z80fi_proto_err = 1'b0;
`endif

  assign bus.z80fi_valid        = valid_q;
  assign bus.z80fi_insn         = out_q.insn;
  assign bus.z80fi_insn_len     = out_q.len;
  assign bus.z80fi_pc_rdata     = out_q.pc;
  assign bus.z80fi_pc_wdata     = pc_next_q;
  assign bus.z80fi_reg1_v       = out_q.reg1_v;
  assign bus.z80fi_reg1_num     = out_q.reg1_num;
  assign bus.z80fi_reg1_data    = out_q.reg1_data;
  assign bus.z80fi_reg2_v       = out_q.reg2_v;
  assign bus.z80fi_reg2_num     = out_q.reg2_num;
  assign bus.z80fi_reg2_data    = out_q.reg2_data;
  assign bus.z80fi_reg_wv       = out_q.regw_v;
  assign bus.z80fi_reg_wnum     = out_q.regw_num;
  assign bus.z80fi_reg_wdata    = out_q.regw_data;
  assign bus.z80fi_mem_rd_v     = out_q.mrd_v;
  assign bus.z80fi_mem_rd_addr  = out_q.mrd_addr;
  assign bus.z80fi_mem_rd_data  = out_q.mrd_data;
  assign bus.z80fi_mem_rd2_v    = out_q.mrd2_v;
  assign bus.z80fi_mem_rd2_addr = out_q.mrd2_addr;
  assign bus.z80fi_mem_rd2_data = out_q.mrd2_data;
  assign bus.z80fi_mem_wr_v     = out_q.mwr_v;
  assign bus.z80fi_mem_wr_addr  = out_q.mwr_addr;
  assign bus.z80fi_mem_wr_data  = out_q.mwr_data;
  assign bus.z80fi_mem_wr2_v    = out_q.mwr2_v;
  assign bus.z80fi_mem_wr2_addr = out_q.mwr2_addr;
  assign bus.z80fi_mem_wr2_data = out_q.mwr2_data;
  assign bus.z80fi_i_rd         = out_q.i_rd;
  assign bus.z80fi_i_rdata      = out_q.i_rdata;
  assign bus.z80fi_i_wr         = out_q.i_wr;
  assign bus.z80fi_i_wdata      = out_q.i_wdata;
  assign bus.z80fi_r_rd         = out_q.r_rd;
  assign bus.z80fi_r_rdata      = out_q.r_rdata;
  assign bus.z80fi_r_wr         = out_q.r_wr;
  assign bus.z80fi_r_wdata      = out_q.r_wdata;
  assign bus.z80fi_f_rd         = out_q.f_rd;
  assign bus.z80fi_f_rdata      = out_q.f_rdata;
  assign bus.z80fi_f_wr         = out_q.f_wr;
  assign bus.z80fi_f_wdata      = out_q.f_wdata;

endmodule

// File: tb/tb_z80fi_retire_monitor.sv
// Self-checking bench for z80fi_retire_monitor: table of instruction vectors plus
// hand-written multi-cycle sequences, with a due-cycle scoreboard on z80fi_valid.
module tb_z80fi_retire_monitor;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  z80fi_retire_monitor_if #(.RNUM_W(3)) bus();

  z80fi_retire_monitor #(.MAX_INSN_BYTES(4), .RNUM_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef Z80FI_PROTO_CHECK_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [31:0] insn;
    logic [2:0]  len;
    logic [31:0] pc;
    logic [19:0] reg1, reg2, regw;
    logic [24:0] mrd, mrd2, mwr, mwr2;
    logic [17:0] si, sr, sf;
  } exp_t;

  typedef struct {
    logic [15:0] pc;
    int          nb;
    logic [47:0] bytes;
    int          nrd, nwr, nmrd, nmwr;
    logic [31:0] exp_insn;
    logic [2:0]  exp_len;
  } vec_t;

  exp_t q[$];
  vec_t vecs[6];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.due = 0; e.insn = '0; e.len = '0; e.pc = '0;
    e.reg1 = '0; e.reg2 = '0; e.regw = '0;
    e.mrd = '0; e.mrd2 = '0; e.mwr = '0; e.mwr2 = '0;
    e.si = '0; e.sr = '0; e.sf = '0;
    return e;
  endfunction

  task automatic check_pkt(input string tag, input exp_t e);
    cmp({tag, ".insn"}, 64'(bus.z80fi_insn), 64'(e.insn));
    cmp({tag, ".len"},  64'(bus.z80fi_insn_len), 64'(e.len));
    cmp({tag, ".pc"},   64'({bus.z80fi_pc_rdata, bus.z80fi_pc_wdata}), 64'(e.pc));
    cmp({tag, ".reg1"}, 64'({bus.z80fi_reg1_v, bus.z80fi_reg1_num, bus.z80fi_reg1_data}), 64'(e.reg1));
    cmp({tag, ".reg2"}, 64'({bus.z80fi_reg2_v, bus.z80fi_reg2_num, bus.z80fi_reg2_data}), 64'(e.reg2));
    cmp({tag, ".regw"}, 64'({bus.z80fi_reg_wv, bus.z80fi_reg_wnum, bus.z80fi_reg_wdata}), 64'(e.regw));
    cmp({tag, ".mrd"},  64'({bus.z80fi_mem_rd_v, bus.z80fi_mem_rd_addr, bus.z80fi_mem_rd_data}), 64'(e.mrd));
    cmp({tag, ".mrd2"}, 64'({bus.z80fi_mem_rd2_v, bus.z80fi_mem_rd2_addr, bus.z80fi_mem_rd2_data}), 64'(e.mrd2));
    cmp({tag, ".mwr"},  64'({bus.z80fi_mem_wr_v, bus.z80fi_mem_wr_addr, bus.z80fi_mem_wr_data}), 64'(e.mwr));
    cmp({tag, ".mwr2"}, 64'({bus.z80fi_mem_wr2_v, bus.z80fi_mem_wr2_addr, bus.z80fi_mem_wr2_data}), 64'(e.mwr2));
    cmp({tag, ".i"},    64'({bus.z80fi_i_rd, bus.z80fi_i_rdata, bus.z80fi_i_wr, bus.z80fi_i_wdata}), 64'(e.si));
    cmp({tag, ".r"},    64'({bus.z80fi_r_rd, bus.z80fi_r_rdata, bus.z80fi_r_wr, bus.z80fi_r_wdata}), 64'(e.sr));
    cmp({tag, ".f"},    64'({bus.z80fi_f_rd, bus.z80fi_f_rdata, bus.z80fi_f_wr, bus.z80fi_f_wdata}), 64'(e.sf));
  endtask

  // Scoreboard: a packet must appear exactly in its due cycle and nowhere else.
  always @(posedge clk) begin : sb
    exp_t e;
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      cmp("valid_pulse", 64'(bus.z80fi_valid), 64'd1);
      check_pkt("pkt", e);
    end else if (bus.z80fi_valid) begin
      cmp("unexpected_valid", 64'(bus.z80fi_valid), 64'd0);
    end
  end

  task automatic push(input exp_t e);
    exp_t x;
    x = e;
    x.due = cyc + 1;
    q.push_back(x);
  endtask

  task automatic idle_in();
    bus.mon_start = 0; bus.mon_pc = '0; bus.mon_byte_v = 0; bus.mon_byte = '0;
    bus.mon_rd_v = 0; bus.mon_rd_num = '0; bus.mon_rd_data = '0;
    bus.mon_wr_v = 0; bus.mon_wr_num = '0; bus.mon_wr_data = '0;
    bus.mon_mrd_v = 0; bus.mon_mwr_v = 0; bus.mon_maddr = '0; bus.mon_mdata = '0;
    bus.mon_i_rd = 0; bus.mon_i_wr = 0; bus.mon_r_rd = 0; bus.mon_r_wr = 0;
    bus.mon_f_rd = 0; bus.mon_f_wr = 0; bus.mon_sdata = '0;
    bus.mon_done = 0; bus.mon_pc_next = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [15:0] rd_val(input int v, input int k);
    return {8'(v), 8'(8'h10 + k)};
  endfunction
  function automatic logic [15:0] wr_val(input int v, input int k);
    return {8'(v), 8'(8'h20 + k)};
  endfunction
  function automatic logic [15:0] mr_addr(input int v, input int k);
    return {8'(8'h80 + v), 8'(k)};
  endfunction
  function automatic logic [15:0] mw_addr(input int v, input int k);
    return {8'(8'h90 + v), 8'(k)};
  endfunction

  task automatic run_vec(input int v, input vec_t t);
    exp_t e;
    int   n;
    n = 2;
    if (t.nb > n) n = t.nb;
    if (t.nrd > n) n = t.nrd;
    if (t.nwr > n) n = t.nwr;
    if (t.nmrd + t.nmwr > n) n = t.nmrd + t.nmwr;
    e = zero_exp();
    e.insn = t.exp_insn;
    e.len  = t.exp_len;
    e.pc   = {t.pc, t.pc + 16'(t.nb)};
    if (t.nrd >= 1) e.reg1 = {1'b1, 3'd1, rd_val(v, 0)};
    if (t.nrd >= 2) e.reg2 = {1'b1, 3'd2, rd_val(v, 1)};
    if (t.nwr >= 1) e.regw = {1'b1, 3'(8 - t.nwr), wr_val(v, t.nwr - 1)};
    if (t.nmrd >= 1) e.mrd  = {1'b1, mr_addr(v, 0), 8'h40};
    if (t.nmrd >= 2) e.mrd2 = {1'b1, mr_addr(v, 1), 8'h41};
    if (t.nmwr >= 1) e.mwr  = {1'b1, mw_addr(v, 0), 8'h60};
    if (t.nmwr >= 2) e.mwr2 = {1'b1, mw_addr(v, 1), 8'h61};
    for (int k = 0; k < n; k++) begin
      idle_in();
      if (k == 0) begin bus.mon_start = 1; bus.mon_pc = t.pc; end
      if (k < t.nb) begin bus.mon_byte_v = 1; bus.mon_byte = t.bytes[8*k +: 8]; end
      if (k < t.nrd) begin bus.mon_rd_v = 1; bus.mon_rd_num = 3'(k + 1); bus.mon_rd_data = rd_val(v, k); end
      if (k < t.nwr) begin bus.mon_wr_v = 1; bus.mon_wr_num = 3'(7 - k); bus.mon_wr_data = wr_val(v, k); end
      if (k < t.nmrd) begin
        bus.mon_mrd_v = 1; bus.mon_maddr = mr_addr(v, k); bus.mon_mdata = 8'(8'h40 + k);
      end else if (k < t.nmrd + t.nmwr) begin
        bus.mon_mwr_v = 1; bus.mon_maddr = mw_addr(v, k - t.nmrd); bus.mon_mdata = 8'(8'h60 + k - t.nmrd);
      end
      if (k == n - 1) begin
        bus.mon_done = 1; bus.mon_pc_next = t.pc + 16'(t.nb);
        push(e);
      end
      step();
    end
    idle_in();
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{pc:16'h1000, nb:1, bytes:48'h00,           nrd:0, nwr:0, nmrd:0, nmwr:0, exp_insn:32'h00000000, exp_len:3'd1};
    vecs[1] = '{pc:16'h1010, nb:3, bytes:48'h123421,       nrd:0, nwr:1, nmrd:0, nmwr:0, exp_insn:32'h00123421, exp_len:3'd3};
    vecs[2] = '{pc:16'h1020, nb:1, bytes:48'h77,           nrd:2, nwr:0, nmrd:0, nmwr:1, exp_insn:32'h00000077, exp_len:3'd1};
    vecs[3] = '{pc:16'h1030, nb:4, bytes:48'h123421DD,     nrd:1, nwr:2, nmrd:1, nmwr:0, exp_insn:32'h123421DD, exp_len:3'd4};
    vecs[4] = '{pc:16'h1040, nb:5, bytes:48'hFF7E0536DD,   nrd:0, nwr:0, nmrd:0, nmwr:3, exp_insn:32'h7E0536DD, exp_len:3'd4};
    vecs[5] = '{pc:16'h1050, nb:2, bytes:48'hB0ED,         nrd:3, nwr:3, nmrd:3, nmwr:2, exp_insn:32'h0000B0ED, exp_len:3'd2};

    idle_in();
    reset = 1;
    repeat (3) step();
    cmp("reset.valid", 64'(bus.z80fi_valid), 64'd0);
    cmp("reset.err", 64'(bus.z80fi_proto_err), 64'd0);
    check_pkt("reset", zero_exp());
    reset = 0;
    step();

    // LD B,C
    bus.mon_start = 1; bus.mon_pc = 16'h0100; bus.mon_byte_v = 1; bus.mon_byte = 8'h41;
    bus.mon_rd_v = 1; bus.mon_rd_num = 3'd1; bus.mon_rd_data = 16'h0034;
    step();
    idle_in();
    bus.mon_wr_v = 1; bus.mon_wr_num = 3'd0; bus.mon_wr_data = 16'h0034;
    bus.mon_done = 1; bus.mon_pc_next = 16'h0101;
    e = zero_exp();
    e.insn = 32'h41; e.len = 3'd1; e.pc = {16'h0100, 16'h0101};
    e.reg1 = {1'b1, 3'd1, 16'h0034}; e.regw = {1'b1, 3'd0, 16'h0034};
    push(e);
    step();
    idle_in();
    step();
    cmp("valid_one_cycle", 64'(bus.z80fi_valid), 64'd0);
    cmp("insn_hold", 64'(bus.z80fi_insn), 64'h41);

    // LD A,I
    bus.mon_start = 1; bus.mon_pc = 16'h0200; bus.mon_byte_v = 1; bus.mon_byte = 8'hED;
    step(); idle_in();
    bus.mon_byte_v = 1; bus.mon_byte = 8'h57;
    step(); idle_in();
    bus.mon_i_rd = 1; bus.mon_sdata = 8'h5A;
    step(); idle_in();
    bus.mon_f_wr = 1; bus.mon_sdata = 8'h44;
    bus.mon_wr_v = 1; bus.mon_wr_num = 3'd7; bus.mon_wr_data = 16'h005A;
    bus.mon_done = 1; bus.mon_pc_next = 16'h0202;
    e = zero_exp();
    e.insn = 32'h57ED; e.len = 3'd2; e.pc = {16'h0200, 16'h0202};
    e.regw = {1'b1, 3'd7, 16'h005A};
    e.si = {1'b1, 8'h5A, 1'b0, 8'h00}; e.sf = {1'b0, 8'h00, 1'b1, 8'h44};
    push(e);
    step(); idle_in();
    step();

    // Back-to-back: retire and start in one cycle, shared strobes land in both
    bus.mon_start = 1; bus.mon_pc = 16'h0300; bus.mon_byte_v = 1; bus.mon_byte = 8'h01;
    step(); idle_in();
    bus.mon_byte_v = 1; bus.mon_byte = 8'h34;
    step(); idle_in();
    bus.mon_done = 1; bus.mon_pc_next = 16'h0303;
    bus.mon_start = 1; bus.mon_pc = 16'h0303; bus.mon_byte_v = 1; bus.mon_byte = 8'hC9;
    bus.mon_mwr_v = 1; bus.mon_maddr = 16'h4000; bus.mon_mdata = 8'h55;
    e = zero_exp();
    e.insn = 32'h00C93401; e.len = 3'd3; e.pc = {16'h0300, 16'h0303};
    e.mwr = {1'b1, 16'h4000, 8'h55};
    push(e);
    step(); idle_in();
    bus.mon_byte_v = 1; bus.mon_byte = 8'h77;
    step(); idle_in();
    bus.mon_done = 1; bus.mon_pc_next = 16'h0305;
    e = zero_exp();
    e.insn = 32'h000077C9; e.len = 3'd2; e.pc = {16'h0303, 16'h0305};
    e.mwr = {1'b1, 16'h4000, 8'h55};
    push(e);
    step(); idle_in();
    step();
    cmp("err_clean", 64'(bus.z80fi_proto_err), 64'd0);

    // Restart without retire discards the first capture
    bus.mon_start = 1; bus.mon_pc = 16'h0400; bus.mon_byte_v = 1; bus.mon_byte = 8'h11;
    bus.mon_rd_v = 1; bus.mon_rd_num = 3'd2; bus.mon_rd_data = 16'h1234;
    step(); idle_in();
    bus.mon_start = 1; bus.mon_pc = 16'h0500; bus.mon_byte_v = 1; bus.mon_byte = 8'h22;
    step(); idle_in();
    cmp("restart_no_pulse", 64'(bus.z80fi_valid), 64'd0);
    bus.mon_done = 1; bus.mon_pc_next = 16'h0501;
    e = zero_exp();
    e.insn = 32'h22; e.len = 3'd1; e.pc = {16'h0500, 16'h0501};
    push(e);
    step(); idle_in();
    step();
    cmp("err_restart", 64'(bus.z80fi_proto_err), 64'(PE));

    for (int v = 0; v < 6; v++) begin
      run_vec(v, vecs[v]);
      step();
    end
    cmp("err_after_drops", 64'(bus.z80fi_proto_err), 64'(PE));

    // Done in IDLE
    reset = 1;
    step();
    reset = 0;
    cmp("reset2.err", 64'(bus.z80fi_proto_err), 64'd0);
    bus.mon_done = 1; bus.mon_pc_next = 16'h1234;
    step(); idle_in();
    cmp("idle_done.valid", 64'(bus.z80fi_valid), 64'd0);
    cmp("idle_done.err", 64'(bus.z80fi_proto_err), 64'(PE));
    step();

    // Reset in the middle of an instruction, then a stray done
    bus.mon_start = 1; bus.mon_pc = 16'h0600; bus.mon_byte_v = 1; bus.mon_byte = 8'h3E;
    bus.mon_wr_v = 1; bus.mon_wr_num = 3'd7; bus.mon_wr_data = 16'h0012;
    step(); idle_in();
    bus.mon_byte_v = 1; bus.mon_byte = 8'h12;
    step(); idle_in();
    reset = 1; bus.mon_done = 1; bus.mon_pc_next = 16'h0602;
    step();
    reset = 0;
    cmp("midreset.valid", 64'(bus.z80fi_valid), 64'd0);
    cmp("midreset.err", 64'(bus.z80fi_proto_err), 64'd0);
    check_pkt("midreset", zero_exp());
    step(); idle_in();
    cmp("after_reset.valid", 64'(bus.z80fi_valid), 64'd0);
    cmp("after_reset.err", 64'(bus.z80fi_proto_err), 64'(PE));
    check_pkt("after_reset", zero_exp());
    repeat (3) step();

    cmp("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
